sprom_mport: RTL
================

Name: sprom_mport

Overview:
- N-channel time-multiplexed synchronous ROM with one shared storage array. Services up to NCH independent requesters, one read issued per clock.
- Two arbitration modes:
  - Fixed-slot: rotating channel slots give deterministic, phase-like latency, as the VIC/CPU sharing needs.
  - Round-robin: work-conserving, for general-purpose sharing.
- Sits between the character/kernal/basic ROM images and multiple fetch agents (CPU, VIC-II, debug/loader).

Parameters:
- aw, 10, address bits; depth is 1<<aw words.
- dw, 8, data bits per word.
- NCH, 2, number of channels (1..8).
- MODE, 0, arbitration mode: 0 = fixed-slot rotation, 1 = round-robin.
- MEM_INIT_FILE, "", hex image loaded with $readmemh at init. If empty, contents are X in sim.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-low (asserted when 0)
- ch_req  in  NCH  per-channel read request, level
- ch_addr  in  NCH*aw  channel i address at [i*aw +: aw]
- ch_ack  out  NCH  one-cycle pulse: channel i data now valid
- ch_do  out  NCH*dw  channel i data at [i*dw +: dw], held until that channel's next ack
- busy  out  1  a read is in flight in stage 1 or stage 2

Behaviour:
- Reset (rst==0 at posedge):
  - ch_ack=0, ch_do=0, busy=0.
  - Slot counter=0, RR pointer=0, both pipeline valid bits cleared.
  - In-flight reads are discarded and never acked.
  - ROM contents are untouched.
- Eligibility: elig = ch_req & ~s1_onehot, where s1_onehot is the channel whose read is in stage 1. At most one in-flight read per channel.
- Grant, cycle G, combinational from elig:
  - MODE 0: grant = channel slot if elig[slot], else none.
    - slot increments every cycle, wraps NCH-1 -> 0, independent of requests.
    - With NCH=1, slot stays 0.
  - MODE 1: lowest index at or above ptr that is eligible, wrapping.
    - ptr <= granted+1 (mod NCH) on a grant; unchanged otherwise.
- Pipeline:
  - End of G: ra <= granted addr; s1 valid/channel registered.
  - Cycle G+1: mem[ra] read asynchronously from ra.
  - End of G+1: ch_do[ch] <= mem[ra]; ch_ack[ch] <= 1.
  - Cycle G+2: ch_ack[ch]=1 for exactly one cycle. Minimum request-to-ack latency is 2 cycles.
- Throughput:
  - One grant per cycle across channels, so NCH>=2 gives back-to-back reads to different channels.
  - A single channel gets at most 1 read per 2 cycles.
- Requester rules:
  - Hold ch_addr stable and ch_req high from assertion until ack.
  - ch_req still high in the ack cycle counts as a new request and is eligible in that same cycle.
  - Dropping ch_req before grant cancels the request. Dropping it after grant does not: the ack still fires.
- ch_do of non-acked channels never changes. Each channel has its own dw-bit hold register, and no output is muxed from the shared read path.
- MODE 0 worst-case latency is NCH+1 cycles; the bench asserts this bound.
- Address width: ch_addr slices are used unmodified, with no wrap or truncation logic needed.
- busy = s1_valid | s2_valid.

Decomposition:
- Shared package myc64_mem_pkg:
  - MODE_FIXED_SLOT=0, MODE_ROUND_ROBIN=1 constants.
  - A function returning the channel index from a one-hot vector.
- Sub-module mport_rr_arb (NCH): elig in, grant one-hot out, internal ptr, synchronous active-low rst. MODE 0 uses its own slot counter in the top level.
- Storage is an inline array with $readmemh, not a separate module.

Test Plan:
- Reset: rst=0 for 3 cycles with all ch_req=1 -> ch_ack=0, ch_do=0, busy=0 throughout. First ack arrives 2 cycles after rst releases (MODE 1).
- MODE 1, NCH=2, image mem[i]=i^8'hA5:
  - ch0 req addr 0x010 and ch1 req addr 0x3FF in the same cycle.
  - ch0 ack at +2 with data 0xB5; ch1 ack at +3 with 0x5A.
  - ch0's ch_do stays 0xB5 during ch1's ack.
- MODE 0, NCH=4:
  - Only ch2 requests, addr 0x001, arriving when slot=3.
  - Grant waits for slot=2, so ack comes 5 cycles after req (the NCH+1 worst case); data 0xA4.
- MODE 1 fairness, NCH=3: all channels hold req high for 30 cycles -> grant order 0,1,2,0,1,2…; each channel acks every 3 cycles; no starvation.
- Back-to-back single channel: ch0 keeps req high with addr sweeping 0..7 on each ack -> acks every 2 cycles, data mem[0..7] in order.
- Reset mid-flight: assert rst in the cycle after a grant -> no ack for that read; pointers, slot and ch_do return to 0.

Source files
------------

// File: rtl/myc64_mem_pkg.sv
// Shared constants and helpers for the multi-port ROM front end.
package myc64_mem_pkg;
  localparam int MODE_FIXED_SLOT  = 0;
  localparam int MODE_ROUND_ROBIN = 1;
  localparam int CH_IDX_W         = 3;

  // Index of the set bit in a one-hot channel vector (0 when empty).
  function automatic logic [CH_IDX_W-1:0] onehot_to_idx(input logic [7:0] oh);
    logic [CH_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = CH_IDX_W'(i);
    end
    return idx;
  endfunction
endpackage

// File: rtl/mport_rr_arb.sv
// Work-conserving round-robin arbiter: first eligible channel at or above the
// pointer wins, and the pointer then moves just past the winner.
module mport_rr_arb
  import myc64_mem_pkg::*;
#(
  parameter int NCH = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] i_elig,
  output logic [NCH-1:0] o_grant
);
  logic [CH_IDX_W-1:0] r_ptr;
  logic [CH_IDX_W-1:0] w_gidx;
  logic                w_found;
  int                  w_dist;
  int                  w_best;

  // Distance from the pointer decides priority; smallest eligible distance wins.
  always_comb begin
    w_gidx  = '0;
    w_found = 1'b0;
    w_dist  = 0;
    w_best  = NCH;
    o_grant = '0;
    for (int i = 0; i < NCH; i++) begin
      w_dist = (i + NCH - int'(r_ptr)) % NCH;
      if (i_elig[i] && (w_dist < w_best)) begin
        w_best  = w_dist;
        w_gidx  = CH_IDX_W'(i);
        w_found = 1'b1;
      end
    end
    for (int i = 0; i < NCH; i++) begin
      o_grant[i] = w_found && (w_gidx == CH_IDX_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= (w_gidx == CH_IDX_W'(NCH - 1)) ? '0 : CH_IDX_W'(w_gidx + CH_IDX_W'(1));
    end
  end
endmodule

// File: rtl/sprom_mport.sv
// Time-multiplexed ROM: one shared array, one read issued per clock, each
// channel with its own data hold register and a one-cycle ack pulse.
module sprom_mport
  import myc64_mem_pkg::*;
#(
  parameter int    aw            = 10,
  parameter int    dw            = 8,
  parameter int    NCH           = 2,
  parameter int    MODE          = 0,
  parameter string MEM_INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    ch_req,
  input  logic [NCH*aw-1:0] ch_addr,
  output logic [NCH-1:0]    ch_ack,
  output logic [NCH*dw-1:0] ch_do,
  output logic              busy
);
  logic [dw-1:0]       r_mem [0:(1<<aw)-1];
  logic                r_s1_valid;
  logic                r_s2_valid;
  logic [CH_IDX_W-1:0] r_s1_ch;
  logic [aw-1:0]       r_ra;
  logic [NCH-1:0]      r_ack;
  logic [dw-1:0]       r_do [NCH];

  logic [NCH-1:0]      w_s1_onehot;
  logic [NCH-1:0]      w_elig;
  logic [NCH-1:0]      w_grant;
  logic [aw-1:0]       w_gnt_addr;
  logic [dw-1:0]       w_rdata;

  // A channel whose read sits in stage 1 may not be granted again yet.
  always_comb begin
    w_s1_onehot = '0;
    for (int i = 0; i < NCH; i++) begin
      w_s1_onehot[i] = r_s1_valid && (r_s1_ch == CH_IDX_W'(i));
    end
  end

  assign w_elig = ch_req & ~w_s1_onehot;

  generate
    if (MODE == MODE_FIXED_SLOT) begin : g_slot
      logic [CH_IDX_W-1:0] r_slot;

      always_ff @(posedge clk) begin
        if (!rst) begin
          r_slot <= '0;
        end else if (r_slot == CH_IDX_W'(NCH - 1)) begin
          r_slot <= '0;
        end else begin
          r_slot <= CH_IDX_W'(r_slot + CH_IDX_W'(1));
        end
      end

      always_comb begin
        w_grant = '0;
        for (int i = 0; i < NCH; i++) begin
          w_grant[i] = w_elig[i] && (r_slot == CH_IDX_W'(i));
        end
      end
    end else begin : g_rr
      mport_rr_arb #(.NCH(NCH)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .i_elig  (w_elig),
        .o_grant (w_grant)
      );
    end
  endgenerate

  always_comb begin
    w_gnt_addr = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_grant[i]) w_gnt_addr = ch_addr[i*aw +: aw];
    end
  end

  assign w_rdata = r_mem[r_ra];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s1_ch    <= '0;
      r_ra       <= '0;
      r_s2_valid <= 1'b0;
      r_ack      <= '0;
      for (int i = 0; i < NCH; i++) r_do[i] <= '0;
    end else begin
      r_s1_valid <= |w_grant;
      r_s1_ch    <= onehot_to_idx(8'(w_grant));
      r_ra       <= w_gnt_addr;
      r_s2_valid <= r_s1_valid;
      r_ack      <= w_s1_onehot;
      // Only the channel completing this cycle updates its hold register.
      for (int i = 0; i < NCH; i++) begin
        if (w_s1_onehot[i]) r_do[i] <= w_rdata;
      end
    end
  end

  generate
    for (genvar g = 0; g < NCH; g++) begin : g_do
      assign ch_do[g*dw +: dw] = r_do[g];
    end
  endgenerate

  assign ch_ack = r_ack;
  assign busy   = r_s1_valid | r_s2_valid;
endmodule
